// File: rtl/rv32i_ctrl_pkg.sv
// Shared types and constants for the RV32I multicycle control unit.
// FSM state codes, opcode values and the per-instruction control bundle.
package rv32i_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t FETCH  = 3'd0;
  localparam state_t DECODE = 3'd1;
  localparam state_t EXE    = 3'd2;
  localparam state_t L_MEM  = 3'd3;
  localparam state_t L_WB   = 3'd4;
  localparam state_t S_RD   = 3'd5;
  localparam state_t S_WR   = 3'd6;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  localparam logic [2:0] WD_ALU    = 3'd0;
  localparam logic [2:0] WD_LOAD   = 3'd1;
  localparam logic [2:0] WD_IMM    = 3'd2;
  localparam logic [2:0] WD_PC_IMM = 3'd3;
  localparam logic [2:0] WD_PC_4   = 3'd4;

  typedef struct packed {
    logic       reg_we;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic [2:0] wd_sel;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       is_load;
    logic       is_store;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/rv32i_instr_decoder.sv
// Combinational instruction decoder: maps an RV32I instruction word to the
// EXE-phase control bundle. Unknown opcodes decode to a flagged NOP.
module rv32i_instr_decoder
  import rv32i_ctrl_pkg::*;
(
  input  logic [31:0] instr_code,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       unused_bits;

  assign opcode      = instr_code[6:0];
  assign funct3      = instr_code[14:12];
  assign funct7_5    = instr_code[30];
  assign unused_bits = ^{instr_code[31], instr_code[29:15], instr_code[11:7]};

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_R: begin
        ctrl.reg_we   = 1'b1;
        ctrl.alu_ctrl = {funct7_5, funct3};
      end
      OP_I: begin
        // only the shift-right pair uses funct7[5] to pick SRAI over SRLI
        ctrl.reg_we   = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.alu_ctrl = {(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
      end
      OP_LUI: begin
        ctrl.reg_we = 1'b1;
        ctrl.wd_sel = WD_IMM;
      end
      OP_AUIPC: begin
        ctrl.reg_we = 1'b1;
        ctrl.wd_sel = WD_PC_IMM;
      end
      OP_JAL: begin
        ctrl.reg_we = 1'b1;
        ctrl.jal    = 1'b1;
        ctrl.wd_sel = WD_PC_4;
      end
      OP_JALR: begin
        ctrl.reg_we = 1'b1;
        ctrl.jal    = 1'b1;
        ctrl.jalr   = 1'b1;
        ctrl.wd_sel = WD_PC_4;
      end
      OP_B: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = {1'b0, funct3};
      end
      OP_L: begin
        ctrl.is_load  = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.alu_ctrl = ALU_ADD;
      end
      OP_S: begin
        ctrl.is_store = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.alu_ctrl = ALU_ADD;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute and the
// load / read-modify-write store bus phases, gating decoder outputs by state.
module rv32i_mc_control_unit
  import rv32i_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        busReady,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic [2:0]  L_mode,
  output logic [2:0]  S_mode,
  output logic        PC_En,
  output logic        busReq,
  output logic        busWe,
  output logic        instrRetired,
  output logic        illegalInstr
);

  state_t     state;
  state_t     state_next;
  ctrl_t      ctrl;
  logic [2:0] funct3;
  logic       in_instr;

  assign funct3 = instrCode[14:12];

  rv32i_instr_decoder u_decoder (
    .instr_code (instrCode),
    .ctrl       (ctrl)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   state_next = DECODE;
      DECODE:  state_next = EXE;
      EXE:     state_next = ctrl.is_load  ? L_MEM :
                            ctrl.is_store ? S_RD  : FETCH;
      L_MEM:   if (busReady) state_next = L_WB;
      L_WB:    state_next = FETCH;
      S_RD:    if (busReady) state_next = S_WR;
      S_WR:    if (busReady) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // instrCode is stable from DECODE on, so decoded ALU/mode fields stay
  // constant across EXE and every bus phase, keeping busAddr steady.
  always_comb begin
    regFileWe     = 1'b0;
    aluControl    = '0;
    aluSrcMuxSel  = 1'b0;
    RFWDSrcMuxSel = WD_ALU;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    L_mode        = '0;
    S_mode        = '0;
    PC_En         = 1'b0;
    busReq        = 1'b0;
    busWe         = 1'b0;
    instrRetired  = 1'b0;
    illegalInstr  = 1'b0;
    in_instr      = (state != FETCH) && (state != DECODE);

    if (in_instr) begin
      aluControl   = ctrl.alu_ctrl;
      aluSrcMuxSel = ctrl.alu_src;
      L_mode       = ctrl.is_load  ? funct3 : 3'b000;
      S_mode       = ctrl.is_store ? funct3 : 3'b000;
    end

    case (state)
      FETCH: PC_En = 1'b1;
      EXE: begin
        regFileWe     = ctrl.reg_we;
        RFWDSrcMuxSel = ctrl.wd_sel;
        branch        = ctrl.branch;
        jal           = ctrl.jal;
        jalr          = ctrl.jalr;
        illegalInstr  = ctrl.illegal;
        instrRetired  = !(ctrl.is_load || ctrl.is_store);
      end
      L_MEM: busReq = 1'b1;
      L_WB: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = WD_LOAD;
        instrRetired  = 1'b1;
      end
      S_RD: busReq = 1'b1;
      S_WR: begin
        busReq       = 1'b1;
        busWe        = 1'b1;
        instrRetired = busReady;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv32i_mc_control_unit.sv
// Self-checking bench: each instruction is expanded into its expected
// per-cycle output trace from the instruction-level timing rules.
module tb_rv32i_mc_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrCode;
  logic        busReady;
  logic        regFileWe;
  logic [3:0]  aluControl;
  logic        aluSrcMuxSel;
  logic [2:0]  RFWDSrcMuxSel;
  logic        branch, jal, jalr;
  logic [2:0]  L_mode, S_mode;
  logic        PC_En, busReq, busWe, instrRetired, illegalInstr;

  int checks = 0;
  int fails  = 0;

  rv32i_mc_control_unit dut (
    .clk(clk), .reset(reset), .instrCode(instrCode), .busReady(busReady),
    .regFileWe(regFileWe), .aluControl(aluControl), .aluSrcMuxSel(aluSrcMuxSel),
    .RFWDSrcMuxSel(RFWDSrcMuxSel), .branch(branch), .jal(jal), .jalr(jalr),
    .L_mode(L_mode), .S_mode(S_mode), .PC_En(PC_En), .busReq(busReq),
    .busWe(busWe), .instrRetired(instrRetired), .illegalInstr(illegalInstr)
  );

  always #5 clk = ~clk;

  logic [22:0] act;
  assign act = {regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel, branch, jal, jalr,
                L_mode, S_mode, PC_En, busReq, busWe, instrRetired, illegalInstr};

  function automatic logic [22:0] vec(input logic we, input logic [3:0] alu, input logic src,
                                      input logic [2:0] sel, input logic br, input logic jl,
                                      input logic jr, input logic [2:0] lm, input logic [2:0] sm,
                                      input logic pce, input logic req, input logic bwe,
                                      input logic ret, input logic ill);
    return {we, alu, src, sel, br, jl, jr, lm, sm, pce, req, bwe, ret, ill};
  endfunction

  localparam logic [22:0] V_FETCH = 23'b0_0000_0_000_000_000_000_10000;

  function automatic bit is_load(input logic [31:0] ins);
    return ins[6:0] == 7'h03;
  endfunction
  function automatic bit is_store(input logic [31:0] ins);
    return ins[6:0] == 7'h23;
  endfunction

  // EXE-cycle outputs straight from the opcode table
  function automatic logic [22:0] exe_vec(input logic [31:0] ins);
    logic [2:0] f3;
    logic       f75;
    f3  = ins[14:12];
    f75 = ins[30];
    case (ins[6:0])
      7'h33: return vec(1, {f75, f3}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      7'h13: return vec(1, {(f3 == 3'd5) ? f75 : 1'b0, f3}, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      7'h37: return vec(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      7'h17: return vec(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      7'h6F: return vec(1, 0, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      7'h67: return vec(1, 0, 0, 4, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
      7'h63: return vec(0, {1'b0, f3}, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      7'h03: return vec(0, 0, 1, 0, 0, 0, 0, f3, 0, 0, 0, 0, 0, 0);
      7'h23: return vec(0, 0, 1, 0, 0, 0, 0, 0, f3, 0, 0, 0, 0, 0);
      default: return vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    endcase
  endfunction

  // Runs one instruction starting in its FETCH cycle (at posedge+1).
  // abort_at >= 0 asserts reset inside that cycle and abandons the instruction.
  task automatic run_instr(input string name, input logic [31:0] ins, input int n,
                           input int m, input int abort_at);
    logic [22:0] exp_q[$];
    int          rdy_q[$];
    logic [2:0]  f3;
    f3 = ins[14:12];
    exp_q.push_back(V_FETCH);  rdy_q.push_back(2);
    exp_q.push_back('0);       rdy_q.push_back(2);
    exp_q.push_back(exe_vec(ins)); rdy_q.push_back(2);
    if (is_load(ins)) begin
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(vec(0, 0, 1, 0, 0, 0, 0, f3, 0, 0, 1, 0, 0, 0)); rdy_q.push_back(0);
      end
      exp_q.push_back(vec(0, 0, 1, 0, 0, 0, 0, f3, 0, 0, 1, 0, 0, 0)); rdy_q.push_back(1);
      exp_q.push_back(vec(1, 0, 1, 1, 0, 0, 0, f3, 0, 0, 0, 0, 1, 0)); rdy_q.push_back(2);
    end else if (is_store(ins)) begin
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(vec(0, 0, 1, 0, 0, 0, 0, 0, f3, 0, 1, 0, 0, 0)); rdy_q.push_back(0);
      end
      exp_q.push_back(vec(0, 0, 1, 0, 0, 0, 0, 0, f3, 0, 1, 0, 0, 0)); rdy_q.push_back(1);
      for (int k = 0; k < m; k++) begin
        exp_q.push_back(vec(0, 0, 1, 0, 0, 0, 0, 0, f3, 0, 1, 1, 0, 0)); rdy_q.push_back(0);
      end
      exp_q.push_back(vec(0, 0, 1, 0, 0, 0, 0, 0, f3, 0, 1, 1, 1, 0)); rdy_q.push_back(1);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      instrCode = ins;
      busReady  = (rdy_q[i] == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_q[i]);
      if (i == abort_at) begin
        #1 reset = 1'b1;
        #1;
        checks++;
        if (act !== V_FETCH) begin
          fails++;
          $display("FAIL %s abort cycle %0d: got %h expected %h (busReq=%b)", name, i, act, V_FETCH, busReq);
        end
        @(posedge clk); #1;
        checks++;
        if (act !== V_FETCH) begin
          fails++;
          $display("FAIL %s held-reset: got %h expected %h", name, act, V_FETCH);
        end
        reset = 1'b0;
        return;
      end
      #3;
      checks++;
      if (act !== exp_q[i]) begin
        fails++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i, act, exp_q[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    instrCode = $urandom;
    busReady  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (act !== V_FETCH) begin
        fails++;
        $display("FAIL reset_outputs: got %h expected %h", act, V_FETCH);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_instr("add",     32'h002081B3, 0, 0, -1);
    run_instr("beq",     32'h00108863, 0, 0, -1);
    run_instr("lw_wait", 32'h00012283, 2, 0, -1);
    run_instr("sb",      32'h001000A3, 0, 0, -1);
    run_instr("jal",     32'h008000EF, 0, 0, -1);
    run_instr("jalr",    32'h00008067, 0, 0, -1);
    run_instr("illegal", 32'h0000007F, 0, 0, -1);
    run_instr("sw_wait", 32'h0020A223, 1, 3, -1);
  endtask

  task automatic test_reset_mid_wait();
    run_instr("lw_abort", 32'h00012283, 3, 0, 4);
    run_instr("after_abort_add", 32'h002081B3, 0, 0, -1);
    run_instr("sw_abort", 32'h0020A223, 0, 3, 5);
    run_instr("after_abort_lui", 32'h123452B7, 0, 0, -1);
  endtask

  task automatic test_random();
    logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
    logic [31:0] ins;
    logic [6:0]  op;
    bit          known;
    for (int t = 0; t < 300; t++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        do begin
          op = 7'($urandom_range(0, 127));
          known = 0;
          for (int k = 0; k < 9; k++) if (ops[k] == op) known = 1;
        end while (known);
      end else begin
        op = ops[$urandom_range(0, 8)];
      end
      ins[6:0] = op;
      run_instr("random", ins, $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_lw0", 32'h0000A303, 0, 0, -1);
    run_instr("b2b_sw0", 32'h0060A023, 0, 0, -1);
    run_instr("b2b_srai", 32'h4050D093, 0, 0, -1);
    run_instr("b2b_sub", 32'h402081B3, 0, 0, -1);
  endtask

  initial begin
    reset     = 1'b1;
    instrCode = '0;
    busReady  = 1'b0;
    test_reset();
    test_directed();
    test_reset_mid_wait();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rv32i_mc_control_unit.md
# rv32i_mc_control_unit

Multicycle control FSM for the RV32I datapath. It decodes `instrCode` and sequences fetch, decode, execute, memory and write-back. It drives every datapath control input (register-file write, ALU op, mux selects, branch/jump, load/store mode, PC enable) and the data-bus request/write-enable, stalling on a data-bus ready handshake.

## Interface
- No parameters.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `instrCode`  in  32  current instruction; combinational from instruction ROM at the current PC
- `busReady`  in  1  data-bus slave completes the access this cycle
- `regFileWe`  out  1  register-file write enable
- `aluControl`  out  4  ALU/branch op code (shared defines)
- `aluSrcMuxSel`  out  1  0 = rs2, 1 = immediate
- `RFWDSrcMuxSel`  out  3  0 = ALU, 1 = load, 2 = imm, 3 = PC+imm, 4 = PC+4
- `branch`, `jal`, `jalr`  out  1 each  PC-source controls
- `L_mode`, `S_mode`  out  3 each  load/store width (funct3)
- `PC_En`  out  1  PC register load enable
- `busReq`  out  1  data-bus access request
- `busWe`  out  1  data-bus write (valid with `busReq`)
- `instrRetired`  out  1  one-cycle pulse in the last cycle of each instruction
- `illegalInstr`  out  1  one-cycle pulse in EXE for an unknown opcode

## Operation
- States: FETCH, DECODE, EXE, L_MEM, L_WB, S_RD, S_WR.
- FETCH: `PC_En`=1; all other outputs 0. Next state is DECODE.
- DECODE: all outputs 0. Next state is EXE.
- EXE, by opcode:
  - R (0110011): `aluSrcMuxSel`=0, `aluControl`={f7[5],f3}, `regFileWe`=1, sel 0.
  - I (0010011): `aluSrcMuxSel`=1, `aluControl`={f3==101 ? f7[5] : 0, f3}, `regFileWe`=1, sel 0.
  - LUI (0110111): sel 2, `regFileWe`=1.
  - AUIPC (0010111): sel 3, `regFileWe`=1.
  - JAL (1101111): `jal`=1, sel 4, `regFileWe`=1.
  - JALR (1100111): `jal`=1, `jalr`=1, sel 4, `regFileWe`=1. Target LSB is not cleared.
  - B (1100011): `branch`=1, `aluSrcMuxSel`=0, `aluControl`={0,f3}.
  - L (0000011) and S (0100011): `aluSrcMuxSel`=1, `aluControl`=ADD.
  - Any other opcode: `illegalInstr`=1, executes as a NOP with PC+4.
- EXE next state: L → L_MEM, S → S_RD, all others → FETCH with `instrRetired`=1.
- From EXE through the end of the instruction, `aluControl`, `aluSrcMuxSel` and `L_mode`/`S_mode`=f3 are held so that `busAddr` stays stable. Modes are 0 outside load/store instructions.
- L_MEM: `busReq`=1, `busWe`=0. Wait while `busReady`=0; go to L_WB on `busReady`.
- L_WB: `regFileWe`=1, sel 1, `instrRetired`=1. Next state is FETCH.
- S_RD: `busReq`=1, `busWe`=0 (read-modify-write read). Go to S_WR on `busReady`.
- S_WR: `busReq`=1, `busWe`=1. On `busReady`: `instrRetired`=1, next state is FETCH.
- Outputs are Moore outputs of state plus the held opcode/funct fields. `instrCode` is stable from DECODE onward because the PC only changes in FETCH.

## Timing
- Reset: state = FETCH. While in reset and in the first cycle after, outputs read FETCH values (`PC_En`=1, all others 0).
- The first FETCH loads PC=0 from the cleared next-PC register.
- Latency:
  - Non-memory instructions: 3 cycles.
  - Load: 5 + n cycles.
  - Store: 5 + n + m cycles.
  - n and m are the wait cycles in L_MEM / S_RD and S_WR.
- The next PC is captured at the end of EXE and committed by `PC_En` in the following FETCH. `jal`/`branch` are asserted only in EXE.
- Wait states: all outputs held constant. During S_WR waits the slave keeps returning the addressed old word, so the merged write data stays stable.
- A `busReady` asserted outside L_MEM/S_RD/S_WR is ignored.
- Reset mid-instruction (including mid-bus-wait): immediate return to FETCH. `busReq` and `regFileWe` drop asynchronously and the access is abandoned.

## Structure
- Package `rv32i_ctrl_pkg`: state enum typedef, opcode localparams. ALU and L/S mode codes stay in the shared defines file.
- Sub-module `rv32i_instr_decoder` (combinational): instruction → per-class control bundle. The top level holds only the FSM, its state register and output gating.

## Test plan
- Reset, then ROM `add x3,x1,x2` at PC 0 with x1=4, x2=8 → `PC_En` in cycles 0 and 3. x3=12 written in cycle 2; PC=4 after cycle 3.
- `beq x1,x1,+16` at PC 4 → `branch`=1 and `aluControl`=0000 in EXE; PC=20 after the next FETCH.
- `lw x5,0(x2)` with `busReady` low for 2 cycles, word 0xDEADBEEF → `busReq` held for 3 cycles. x5=0xDEADBEEF in L_WB; 7 cycles total.
- `sb x1,1(x0)` with old word 0x11223344, x1=0x000000AA, zero-wait → S_RD then S_WR. `busWe` only in S_WR; written word 0x1122AA44 (byte lane 1).
- `jal x1,+8` at PC 8 → x1=12, PC=16. `jalr x0,0(x1)` → PC=12.
- Opcode 0x7F → `illegalInstr` pulses once, no register write, PC advances by 4. Reset asserted during an L_MEM wait → `busReq`=0 in the same cycle, next state FETCH.
